// File: rtl/out_port_if.sv
// out_port W-bus load / display-bus bundle.
// Master drives load and mode, slave returns display values.
interface out_port_if;
  logic [7:0] WBUS;
  logic       LO;
  logic       MODE_WE;
  logic       DEC_IN;
  logic [7:0] OBUS;
  logic [1:0] HUND;
  logic       OVF;
  logic       BUSY;
  logic [7:0] OUTV;

  modport master (
    output WBUS, LO, MODE_WE, DEC_IN,
    input  OBUS, HUND, OVF, BUSY, OUTV
  );

  modport slave (
    input  WBUS, LO, MODE_WE, DEC_IN,
    output OBUS, HUND, OVF, BUSY, OUTV
  );
endinterface

// File: rtl/out_port.sv
// Output port: captures W-bus, drives hex or
// double-dabble BCD onto the display bus.
module out_port #(
  parameter logic DEC_RST = 1'b0
) (
  input  logic         clk,
  input  logic         CLR,
  out_port_if.slave    bus
);
  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_n;
  logic [7:0]  oreg, oreg_n;
  logic        dec, dec_n;
  logic [11:0] bcd, bcd_n;
  logic [19:0] scr, scr_n;
  logic [3:0]  cnt, cnt_n;
  logic [19:0] adj, step;

  // Add-3 to each BCD field >= 5, then shift one bit.
  always_comb begin
    adj = scr;
    for (int i = 0; i < 3; i++) begin
      if (scr[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = scr[8+4*i +: 4] + 4'd3;
    end
    step = adj << 1;
  end

  // Next-state: load/restart wins over iteration and commit.
  always_comb begin
    state_n = state;
    oreg_n  = oreg;
    bcd_n   = bcd;
    scr_n   = scr;
    cnt_n   = cnt;
    dec_n   = bus.MODE_WE ? bus.DEC_IN : dec;
    if (bus.LO) begin
      oreg_n  = bus.WBUS;
      scr_n   = {12'b0, bus.WBUS};
      cnt_n   = 4'd0;
      state_n = CONV;
    end else if (state == CONV) begin
      scr_n = step;
      cnt_n = cnt + 4'd1;
      if (cnt == 4'd7) begin
        bcd_n   = step[19:8];
        state_n = IDLE;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      oreg  <= 8'd0;
      dec   <= DEC_RST;
      bcd   <= 12'd0;
      scr   <= 20'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      oreg  <= oreg_n;
      dec   <= dec_n;
      bcd   <= bcd_n;
      scr   <= scr_n;
      cnt   <= cnt_n;
    end
  end

  // Display outputs depend only on committed values.
  always_comb begin
    bus.OBUS = dec ? bcd[7:0] : oreg;
    bus.HUND = dec ? bcd[9:8] : 2'd0;
    bus.OVF  = dec && (bcd[11:8] != 4'd0);
    bus.BUSY = (state == CONV);
    bus.OUTV = oreg;
  end
endmodule

// File: doc/out_port.md
# out_port

Output-port stage that sits directly upstream of the seven-segment display driver: it captures the W-bus value on the output-load control strobe and drives the 8-bit OBUS that the display multiplexer consumes. In hex mode OBUS carries the captured byte unchanged. In decimal mode a sequential shift-add-3 (double-dabble) converter produces packed BCD, and OBUS carries the tens/units digits. The hundreds digit and an overflow flag are exported separately for the LEDs.

## Interface
- DEC_RST, default 1'b0, reset value of the internal mode latch (0 = hex, 1 = decimal)
- clk  input  1  system clock; all state updates on rising edge
- CLR  input  1  reset, asynchronous, active-high
- WBUS  input  8  W-bus data, sampled when LO=1
- LO  input  1  output-register load strobe, sampled at rising clk
- MODE_WE  input  1  mode write enable; when 1 at a rising edge, the mode latch takes DEC_IN
- DEC_IN  input  1  requested mode (0 hex, 1 decimal)
- OBUS  output  8  display byte: oreg in hex mode, {tens,units} BCD in decimal mode
- HUND  output  2  committed hundreds digit (0..2); forced 0 in hex mode
- OVF  output  1  1 when in decimal mode and HUND != 0
- BUSY  output  1  conversion in progress
- OUTV  output  8  raw captured output register (oreg), independent of mode

## Operation
- Registers:
  - oreg[7:0]: captured byte.
  - dec: mode latch.
  - bcd[11:0]: committed BCD result.
  - scr[19:0]: scratch, {bcd_work[11:0], bin[7:0]}.
  - cnt[3:0]: iteration counter.
  - state: IDLE or CONV.
- OBUS, HUND and OVF are combinational from oreg, bcd and dec only. They never expose scr.
- IDLE:
  - If LO=1: oreg<=WBUS, scr<={12'b0,WBUS}, cnt<=0, state<=CONV.
  - Otherwise hold all state.
- CONV, one iteration per clk:
  - Adjust: each 4-bit BCD field of scr[19:8] that is >=5 gets +3.
  - Shift: the adjusted 20-bit value shifts left by 1.
  - cnt<=cnt+1.
  - On the iteration where cnt==7: bcd<=the adjusted-and-shifted scr[19:8], state<=IDLE.
- LO=1 in CONV (restart):
  - The current conversion is abandoned and bcd keeps its old value.
  - oreg and scr reload from WBUS, cnt<=0, and state stays CONV.
- MODE_WE is independent of LO and state. A mode change takes effect on OBUS, HUND and OVF the cycle after the edge. It never alters oreg, bcd or the conversion in progress.
- BUSY = (state==CONV).
- Width rules:
  - Max input 255, which gives bcd = 0x255.
  - The hundreds field never exceeds 2, so HUND = bcd[9:8] and bcd[11:10] is always 0.
  - The +3 adjust is 4-bit per field with no carry between fields. The >=5 rule guarantees no field overflow.
- Reset:
  - CLR=1 immediately gives: oreg=0, bcd=0, scr=0, cnt=0, state=IDLE, dec=DEC_RST.
  - Outputs under reset: OBUS=0x00, HUND=0, OVF=0, BUSY=0, OUTV=0x00.
  - CLR during CONV aborts the conversion with no commit.

## Timing
- Reference edge: LO sampled high at edge E0.
- After E0:
  - OUTV = WBUS(E0), and in hex mode OBUS = WBUS(E0).
  - BUSY=1.
- Conversion:
  - Iterations execute at edges E1..E8.
  - At E8: bcd commits, BUSY=0, and decimal OBUS, HUND and OVF update.
  - BUSY is high for exactly 8 cycles.
- Between E0 and E8, decimal-mode outputs show the previously committed bcd.
- Restart:
  - LO at edge Ek (1<=k<=8) redefines E0=Ek.
  - If k=8, the restart takes precedence: there is no commit at that edge and BUSY stays 1.
- The earliest next accepted load is E8 (restart) or any later edge. Throughput is 1 conversion per 9 edges when LO pulses are spaced >=9 apart.
- The downstream display samples OBUS asynchronously to this block's updates. OBUS changes only after clk edges and never mid-cycle.

## Test plan
- Decimal, single load: DEC_IN=1 with MODE_WE pulse, then LO pulse with WBUS=0x7B.
  - Before E8: BUSY=1 for 8 cycles and OBUS = previous value (0x00).
  - After E8: OBUS=0x23, HUND=1, OVF=1, OUTV=0x7B.
- Hex mode and boundaries: dec=0, load 0xFF.
  - After E0: OBUS=0xFF, HUND=0, OVF=0.
  - Then switch to decimal after E8: OBUS=0x55, HUND=2, OVF=1.
  - Then load 0x00: after E8, OBUS=0x00, OVF=0.
- Exhaustive decimal: for every WBUS 0..255 with LO spaced 9 cycles apart, {HUND,OBUS} equals the BCD of the value at E8, and BUSY falls exactly 8 cycles after each LO.
- Restart:
  - LO with 0x63, then LO with 0x09 at E4: BUSY stays 1 until 8 edges after the second LO, and final OBUS=0x09.
  - Never 0x99 / HUND=0 partials, never the 0x63 result, no intermediate commit.
  - Repeat with the second LO at E8: no commit of 0x63.
- Reset mid-operation: load 0xC8 in decimal mode, assert CLR asynchronously at E3 (between edges).
  - Outputs immediately read OBUS=0x00, HUND=0, OVF=0, BUSY=0, OUTV=0x00.
  - After release, load 0x64 gives OBUS=0x00, HUND=1, OVF=1.
- Mode toggle while busy: committed value 0x2A (decimal 42); load 0x0F, toggle mode at E2.
  - Hex mode shows 0x0F.
  - Decimal mode shows 0x42 until E8, then 0x15.
